// File: rtl/data_bus_arbiter.sv
// Two-master arbiter in front of a single-port synchronous RAM.
// Master 0 is the CPU data port and master 1 is the accelerator.
// Grants are decided combinationally, so an uncontested master sees no wait state.
// Under contention, the favoured master keeps the bus for MAX_BURST contested
// cycles and then yields, so neither master can be starved.
// Read data comes back one cycle after the read grant. It is steered only to the
// master that issued the read; the other master sees zeros.
module data_bus_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req_i,
  input  logic [3:0]  m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic        m1_req_i,
  input  logic [3:0]  m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic        m0_gnt_o,
  output logic        m1_gnt_o,
  output logic        m0_rvalid_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m0_data_o,
  output logic [31:0] m1_data_o,
  output logic        slv_en_o,
  output logic [3:0]  slv_we_o,
  output logic [31:0] slv_addr_o,
  output logic [31:0] slv_data_o,
  input  logic [31:0] slv_data_i
);

  // Last streak value before the favoured master must hand over priority.
  localparam logic [7:0] STREAK_LAST = 8'(MAX_BURST - 1);

  logic       prio_r;     // 0: m0 wins contention, 1: m1 wins
  logic [7:0] streak_r;   // contested cycles won by the current favourite
  logic       rd_pend_r;  // a read was granted last cycle
  logic       owner_r;    // master that issued that read

  logic       contested;
  logic       gnt0;
  logic       gnt1;
  logic       any_gnt;
  logic       rd_grant;

  // Grant decision: a sole requester always wins; on contention prio_r decides.
  // Reset masks both grants so nothing reaches the RAM while reset is high.
  always_comb begin
    contested = m0_req_i & m1_req_i;
    gnt0      = ~reset & m0_req_i & (~m1_req_i | ~prio_r);
    gnt1      = ~reset & m1_req_i & (~m0_req_i |  prio_r);
    any_gnt   = gnt0 | gnt1;
  end

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  // Route the granted master to the RAM port. The RAM port is zeroed when idle
  // so the bus never shows stale address or data.
  always_comb begin
    slv_en_o   = 1'b0;
    slv_we_o   = 4'h0;
    slv_addr_o = 32'h0;
    slv_data_o = 32'h0;
    if (gnt0) begin
      slv_en_o   = 1'b1;
      slv_we_o   = m0_we_i;
      slv_addr_o = m0_addr_i;
      slv_data_o = m0_data_i;
    end else if (gnt1) begin
      slv_en_o   = 1'b1;
      slv_we_o   = m1_we_i;
      slv_addr_o = m1_addr_i;
      slv_data_o = m1_data_i;
    end
  end

  // A granted access with all byte enables low is a read.
  assign rd_grant = any_gnt & (slv_we_o == 4'h0);

  // Fairness state: count contested cycles and hand over priority after MAX_BURST.
  // Any uncontested cycle restarts the count without changing priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_r   <= 1'b0;
      streak_r <= 8'd0;
    end else if (contested) begin
      if (streak_r == STREAK_LAST) begin
        prio_r   <= ~prio_r;
        streak_r <= 8'd0;
      end else begin
        streak_r <= streak_r + 8'd1;
      end
    end else begin
      streak_r <= 8'd0;
    end
  end

  // Remember which master issued the read so the RAM response reaches that
  // master next cycle. Reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_r <= 1'b0;
      owner_r   <= 1'b0;
    end else begin
      rd_pend_r <= rd_grant;
      if (rd_grant) begin
        owner_r <= gnt1;
      end
    end
  end

  // Steer the returning read data to its owner and give the other master zeros.
  always_comb begin
    m0_rvalid_o = rd_pend_r & ~owner_r;
    m1_rvalid_o = rd_pend_r &  owner_r;
    m0_data_o   = m0_rvalid_o ? slv_data_i : 32'h0;
    m1_data_o   = m1_rvalid_o ? slv_data_i : 32'h0;
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter.
// Instance dut runs with the default MAX_BURST of 4.
// Instance dut1 runs with MAX_BURST = 1.
module tb_data_bus_arbiter;

  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req_i, m1_req_i;
  logic [3:0]  m0_we_i, m1_we_i;
  logic [31:0] m0_addr_i, m1_addr_i, m0_data_i, m1_data_i;
  logic [31:0] slv_data_i;

  logic        a_gnt0, a_gnt1, a_rv0, a_rv1, a_en;
  logic [31:0] a_do0, a_do1, a_addr, a_data;
  logic [3:0]  a_we;
  logic        b_gnt0, b_gnt1, b_rv0, b_rv1, b_en;
  logic [31:0] b_do0, b_do1, b_addr, b_data;
  logic [3:0]  b_we;

  data_bus_arbiter #(.MAX_BURST(BURST)) dut (
    .clk(clk), .reset(reset),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
    .m0_gnt_o(a_gnt0), .m1_gnt_o(a_gnt1), .m0_rvalid_o(a_rv0), .m1_rvalid_o(a_rv1),
    .m0_data_o(a_do0), .m1_data_o(a_do1), .slv_en_o(a_en), .slv_we_o(a_we),
    .slv_addr_o(a_addr), .slv_data_o(a_data), .slv_data_i(slv_data_i)
  );

  data_bus_arbiter #(.MAX_BURST(1)) dut1 (
    .clk(clk), .reset(reset),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
    .m0_gnt_o(b_gnt0), .m1_gnt_o(b_gnt1), .m0_rvalid_o(b_rv0), .m1_rvalid_o(b_rv1),
    .m0_data_o(b_do0), .m1_data_o(b_do1), .slv_en_o(b_en), .slv_we_o(b_we),
    .slv_addr_o(b_addr), .slv_data_o(b_data), .slv_data_i(slv_data_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, r0, r1;
    logic [3:0]  we0, we1;
    logic [31:0] a0, d0, a1, d1, sdi;
    logic        g0, g1;
    logic [3:0]  swe;
    logic [31:0] saddr, sdata;
    logic        rv0, rv1;
    logic [31:0] do0, do1;
    logic        chk_rd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst,
                     input logic r0, input logic [3:0] we0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic r1, input logic [3:0] we1, input logic [31:0] a1, input logic [31:0] d1,
                     input logic [31:0] sdi, input logic g0, input logic g1, input logic [3:0] swe,
                     input logic [31:0] saddr, input logic [31:0] sdata, input logic rv0, input logic rv1,
                     input logic [31:0] do0, input logic [31:0] do1, input logic chk_rd);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.we1 = we1; v.a1 = a1; v.d1 = d1; v.sdi = sdi;
    v.g0 = g0; v.g1 = g1; v.swe = swe; v.saddr = saddr; v.sdata = sdata;
    v.rv0 = rv0; v.rv1 = rv1; v.do0 = do0; v.do1 = do1; v.chk_rd = chk_rd;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic r0, input logic [3:0] we0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic r1, input logic [3:0] we1, input logic [31:0] a1,
                       input logic [31:0] d1, input logic [31:0] sdi);
    reset = rst; m0_req_i = r0; m0_we_i = we0; m0_addr_i = a0; m0_data_i = d0;
    m1_req_i = r1; m1_we_i = we1; m1_addr_i = a1; m1_data_i = d1; slv_data_i = sdi;
  endtask

  // Reference model state, one slot per instance.
  // fav is the master that wins contention.
  // used counts the contested cycles it has won so far.
  // pend/own describe the read waiting for its data.
  int   burst[2] = '{BURST, 1};
  int   fav[2], used[2];
  bit   pend[2], own[2];
  bit   eg0[2], eg1[2];
  logic [3:0] egwe[2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      fav[k] = 0; used[k] = 0; pend[k] = 0; own[k] = 0;
    end
  endfunction

  // Grants implied by the arbitration rules for the current inputs.
  function automatic void model_predict();
    for (int k = 0; k < 2; k++) begin
      eg0[k] = !reset && m0_req_i && (!m1_req_i || fav[k] == 0);
      eg1[k] = !reset && m1_req_i && (!m0_req_i || fav[k] == 1);
      egwe[k] = eg0[k] ? m0_we_i : (eg1[k] ? m1_we_i : 4'h0);
    end
  endfunction

  // State changes at the clock edge.
  function automatic void model_advance();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        fav[k] = 0; used[k] = 0; pend[k] = 0; own[k] = 0;
      end else begin
        if (m0_req_i && m1_req_i) begin
          used[k]++;
          if (used[k] == burst[k]) begin
            fav[k] = 1 - fav[k];
            used[k] = 0;
          end
        end else begin
          used[k] = 0;
        end
        pend[k] = (eg0[k] || eg1[k]) && egwe[k] == 4'h0;
        if (pend[k]) own[k] = eg1[k];
      end
    end
  endfunction

  initial begin
    logic [31:0] e_addr, e_data;
    bit hold0, hold1;
    int wait0, wait1;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // ---- Directed table ----
    add(1, 1,0,32'h4,32'h5,       1,0,32'h8,32'h9,          32'h77,       0,0,4'h0,32'h0,32'h0,             0,0,32'h0,32'h0,1);
    add(0, 0,0,0,0,               0,0,0,0,                  32'h66,       0,0,4'h0,32'h0,32'h0,             0,0,32'h0,32'h0,1);
    add(0, 1,0,32'h100,0,         0,0,0,0,                  32'h55,       1,0,4'h0,32'h100,32'h0,           0,0,32'h0,32'h0,1);
    add(0, 0,0,0,0,               0,0,0,0,                  32'hDEADBEEF, 0,0,4'h0,32'h0,32'h0,             1,0,32'hDEADBEEF,32'h0,1);
    add(0, 0,0,0,0,               1,4'hF,32'h200,32'h12345678, 32'h1,     0,1,4'hF,32'h200,32'h12345678,    0,0,32'h0,32'h0,1);
    add(0, 0,0,0,0,               0,0,0,0,                  32'hAAAA5555, 0,0,4'h0,32'h0,32'h0,             0,0,32'h0,32'h0,1);
    add(0, 1,0,32'h10,0,          0,0,0,0,                  32'hBAD,      1,0,4'h0,32'h10,32'h0,            0,0,32'h0,32'h0,1);
    add(0, 0,0,0,0,               1,0,32'h20,0,             32'h11111111, 0,1,4'h0,32'h20,32'h0,            1,0,32'h11111111,32'h0,1);
    add(0, 1,0,32'h10,0,          0,0,0,0,                  32'h22222222, 1,0,4'h0,32'h10,32'h0,            0,1,32'h0,32'h22222222,1);
    add(0, 0,0,0,0,               0,0,0,0,                  32'h33333333, 0,0,4'h0,32'h0,32'h0,             1,0,32'h33333333,32'h0,1);
    add(0, 0,0,0,0,               0,0,0,0,                  32'h44,       0,0,4'h0,32'h0,32'h0,             0,0,32'h0,32'h0,1);
    // Continuous contention with writes: four cycles each, then m0 again.
    for (int i = 0; i < 9; i++) begin
      if (i < 4 || i == 8)
        add(0, 1,4'h1,32'h40,32'hA0, 1,4'h2,32'h80,32'hB0, 32'h0, 1,0,4'h1,32'h40,32'hA0, 0,0,32'h0,32'h0,1);
      else
        add(0, 1,4'h1,32'h40,32'hA0, 1,4'h2,32'h80,32'hB0, 32'h0, 0,1,4'h2,32'h80,32'hB0, 0,0,32'h0,32'h0,1);
    end
    add(0, 0,0,0,0, 0,0,0,0, 32'h0, 0,0,4'h0,32'h0,32'h0, 0,0,32'h0,32'h0,1);
    // Two contested cycles, m1 drops once, then m0 keeps four more wins.
    for (int i = 0; i < 2; i++)
      add(0, 1,4'h1,32'h40,32'hA0, 1,4'h2,32'h80,32'hB0, 32'h0, 1,0,4'h1,32'h40,32'hA0, 0,0,32'h0,32'h0,1);
    add(0, 1,4'h1,32'h40,32'hA0, 0,4'h2,32'h80,32'hB0, 32'h0, 1,0,4'h1,32'h40,32'hA0, 0,0,32'h0,32'h0,1);
    for (int i = 0; i < 4; i++)
      add(0, 1,4'h1,32'h40,32'hA0, 1,4'h2,32'h80,32'hB0, 32'h0, 1,0,4'h1,32'h40,32'hA0, 0,0,32'h0,32'h0,1);
    // m1 now has priority and issues a read; reset hits while that read is pending.
    add(0, 1,0,32'h40,32'hA0, 1,0,32'h80,32'hB0, 32'h0,  0,1,4'h0,32'h80,32'hB0, 0,0,32'h0,32'h0,1);
    add(1, 1,0,32'h40,32'hA0, 1,0,32'h80,32'hB0, 32'h5A, 0,0,4'h0,32'h0,32'h0,   0,0,32'h0,32'h0,0);
    add(0, 1,0,32'h40,32'hA0, 1,0,32'h80,32'hB0, 32'h99, 1,0,4'h0,32'h40,32'hA0, 0,0,32'h0,32'h0,1);
    add(0, 0,0,0,0, 0,0,0,0, 32'hCAFE, 0,0,4'h0,32'h0,32'h0, 1,0,32'hCAFE,32'h0,1);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].r0, tbl[i].we0, tbl[i].a0, tbl[i].d0,
            tbl[i].r1, tbl[i].we1, tbl[i].a1, tbl[i].d1, tbl[i].sdi);
      #4;
      $display("row %0d: rst=%b req=%b%b gnt=%b%b addr=%h rvalid=%b%b", i, tbl[i].rst,
               tbl[i].r0, tbl[i].r1, a_gnt0, a_gnt1, a_addr, a_rv0, a_rv1);
      check($sformatf("row%0d_gnt0", i), 32'(a_gnt0), 32'(tbl[i].g0));
      check($sformatf("row%0d_gnt1", i), 32'(a_gnt1), 32'(tbl[i].g1));
      check($sformatf("row%0d_en", i), 32'(a_en), 32'(tbl[i].g0 | tbl[i].g1));
      check($sformatf("row%0d_slv_we", i), 32'(a_we), 32'(tbl[i].swe));
      check($sformatf("row%0d_slv_addr", i), a_addr, tbl[i].saddr);
      check($sformatf("row%0d_slv_data", i), a_data, tbl[i].sdata);
      if (tbl[i].chk_rd) begin
        check($sformatf("row%0d_rvalid0", i), 32'(a_rv0), 32'(tbl[i].rv0));
        check($sformatf("row%0d_rvalid1", i), 32'(a_rv1), 32'(tbl[i].rv1));
        check($sformatf("row%0d_data0", i), a_do0, tbl[i].do0);
        check($sformatf("row%0d_data1", i), a_do1, tbl[i].do1);
      end
      @(posedge clk);
      #1;
    end

    // ---- Hand sequence: contention from reset, with MAX_BURST 4 and with MAX_BURST 1 ----
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 4'h3, 32'h1000 + i, 32'h0, 1, 4'hC, 32'h2000 + i, 32'h0, 32'h0);
      #4;
      $display("contend %0d: burst4 gnt=%b%b burst1 gnt=%b%b", i, a_gnt0, a_gnt1, b_gnt0, b_gnt1);
      check($sformatf("burst1_gnt1_%0d", i), 32'(b_gnt1), 32'(i % 2));
      check($sformatf("burst1_gnt0_%0d", i), 32'(b_gnt0), 32'(1 - i % 2));
      check($sformatf("burst4_gnt1_%0d", i), 32'(a_gnt1), 32'((i / 4) % 2));
      @(posedge clk);
      #1;
    end

    // ---- Randomized run against the reference model ----
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    model_reset();
    hold0 = 0; hold1 = 0; wait0 = 0; wait1 = 0;
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      if (!hold0) begin
        m0_req_i  = ($urandom_range(0, 99) < 75);
        m0_we_i   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        m0_addr_i = $urandom;
        m0_data_i = $urandom;
      end
      if (!hold1) begin
        m1_req_i  = ($urandom_range(0, 99) < 75);
        m1_we_i   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        m1_addr_i = $urandom;
        m1_data_i = $urandom;
      end
      slv_data_i = $urandom;
      model_predict();
      #4;
      $display("rand %0d: rst=%b req=%b%b gnt=%b%b/%b%b rvalid=%b%b/%b%b", n, reset, m0_req_i, m1_req_i,
               a_gnt0, a_gnt1, b_gnt0, b_gnt1, a_rv0, a_rv1, b_rv0, b_rv1);
      e_addr = eg0[0] ? m0_addr_i : (eg1[0] ? m1_addr_i : 32'h0);
      e_data = eg0[0] ? m0_data_i : (eg1[0] ? m1_data_i : 32'h0);
      check("rand_gnt0", 32'(a_gnt0), 32'(eg0[0]));
      check("rand_gnt1", 32'(a_gnt1), 32'(eg1[0]));
      check("rand_en", 32'(a_en), 32'(eg0[0] | eg1[0]));
      check("rand_slv_we", 32'(a_we), 32'(egwe[0]));
      check("rand_slv_addr", a_addr, e_addr);
      check("rand_slv_data", a_data, e_data);
      check("rand_rvalid0", 32'(a_rv0), 32'(pend[0] && !own[0]));
      check("rand_rvalid1", 32'(a_rv1), 32'(pend[0] && own[0]));
      check("rand_data0", a_do0, (pend[0] && !own[0]) ? slv_data_i : 32'h0);
      check("rand_data1", a_do1, (pend[0] && own[0]) ? slv_data_i : 32'h0);
      check("rand_b1_gnt0", 32'(b_gnt0), 32'(eg0[1]));
      check("rand_b1_gnt1", 32'(b_gnt1), 32'(eg1[1]));
      check("rand_b1_en", 32'(b_en), 32'(eg0[1] | eg1[1]));
      check("rand_b1_rvalid0", 32'(b_rv0), 32'(pend[1] && !own[1]));
      check("rand_b1_rvalid1", 32'(b_rv1), 32'(pend[1] && own[1]));
      check("rand_b1_data1", b_do1, (pend[1] && own[1]) ? slv_data_i : 32'h0);
      // A master that keeps requesting must be served within BURST denied cycles.
      if (reset) begin
        wait0 = 0; wait1 = 0;
      end else begin
        if (m0_req_i && !a_gnt0) wait0++;
        else if (a_gnt0) begin
          check("wait_bound_m0", 32'(wait0 <= BURST), 32'd1);
          wait0 = 0;
        end
        if (m1_req_i && !a_gnt1) wait1++;
        else if (a_gnt1) begin
          check("wait_bound_m1", 32'(wait1 <= BURST), 32'd1);
          wait1 = 0;
        end
      end
      @(posedge clk);
      #1;
      model_advance();
      hold0 = m0_req_i && !eg0[0];
      hold1 = m1_req_i && !eg1[0];
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
